// File: rtl/truth_table_capture.sv
// truth_table_capture: observes (in_vec, in_f) samples from a function under
// test and rebuilds its truth table as a minterm mask, tracking coverage and
// comparing the finished table against exp_mask.
// Optional feature: define TT_CONFLICT_EN to flag contradictory samples
// (sticky conflict, first conflicting index, first-recorded value wins).
// Without it, a contradictory sample overwrites the entry (last wins).
module truth_table_capture #(
    parameter  int N_IN = 4,
    localparam int TT_W = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_f,
    input  logic [TT_W-1:0] exp_mask,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] minterms,
    output logic [TT_W-1:0] seen,
    output logic [N_IN:0]   seen_cnt,
    output logic            match,
    output logic            conflict,
    output logic [N_IN-1:0] conflict_idx
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    logic [TT_W-1:0] hit;
    logic            is_new;
    logic            is_conf;
    logic [TT_W-1:0] seen_upd;
    logic [TT_W-1:0] min_upd;

    // Decode the incoming sample against the table recorded so far
    always_comb begin
        hit         = '0;
        hit[in_vec] = 1'b1;
        is_new      = ~seen[in_vec];
        is_conf     = seen[in_vec] && (minterms[in_vec] != in_f);
        seen_upd    = seen | hit;
`ifdef TT_CONFLICT_EN
        // first recorded value is kept; only new indices are written
        if (is_new)
            min_upd = in_f ? (minterms | hit) : (minterms & ~hit);
        else
            min_upd = minterms;
`else
        // unrecorded entries are already 0, so writing unconditionally
        // covers both new samples and last-wins overwrites
        min_upd = in_f ? (minterms | hit) : (minterms & ~hit);
`endif
    end

    // Capture state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            match    <= 1'b0;
            minterms <= '0;
            seen     <= '0;
            seen_cnt <= '0;
        end else if (start) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            done     <= 1'b0;
            match    <= 1'b0;
            minterms <= '0;
            seen     <= '0;
            seen_cnt <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (in_valid) begin
                        seen     <= seen_upd;
                        minterms <= min_upd;
                        if (is_new)
                            seen_cnt <= seen_cnt + (N_IN+1)'(1);
                        if (&seen_upd) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (min_upd == exp_mask);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TT_CONFLICT_EN
    // Sticky conflict flag; index of the first contradiction only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict     <= 1'b0;
            conflict_idx <= '0;
        end else if (start) begin
            conflict     <= 1'b0;
            conflict_idx <= '0;
        end else if (state == CAPTURE && in_valid && is_conf && !conflict) begin
            conflict     <= 1'b1;
            conflict_idx <= in_vec;
        end
    end
`else
    assign conflict     = 1'b0;
    assign conflict_idx = '0;
`endif

endmodule

// File: doc/truth_table_capture.md
# truth_table_capture

Sequential response-side counterpart to our combinational exercise functions: it observes a stream of (input-vector, output-bit) samples from a device under test and reconstructs that function's truth table as a minterm mask. It tracks coverage until every input combination has been seen, detects contradictory samples, and compares the captured table against an expected mask. It sits next to a stimulus sweep driving a lab function, so pass/fail is decided in hardware instead of by reading a monitor log.

## Interface
- N_IN, 4, number of function inputs; the truth table has TT_W = 2**N_IN entries (derived, not overridable)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  one-cycle pulse; clears the capture state and begins a new capture
- in_valid  input  1  the sample on in_vec/in_f is valid this cycle
- in_vec  input  N_IN  input combination; MSB is the first input (a), so {a,b,c,d} maps to index a*8+b*4+c*2+d
- in_f  input  1  function output observed for in_vec
- exp_mask  input  TT_W  expected minterm mask, held stable during capture
- busy  output  1  high in CAPTURE
- done  output  1  high in DONE
- minterms  output  TT_W  bit i = recorded f for index i (0 if not seen)
- seen  output  TT_W  bit i = index i recorded
- seen_cnt  output  N_IN+1  popcount of seen
- match  output  1  valid in DONE: minterms == exp_mask
- conflict  output  1  sticky: some index reported both 0 and 1
- conflict_idx  output  N_IN  first index that conflicted

## Operation
- States: IDLE (reset), CAPTURE, DONE.
- IDLE -> CAPTURE on start. DONE -> CAPTURE on start. In CAPTURE, start restarts the capture in place.
- start in any state, on its edge: clear minterms, seen, seen_cnt, match, conflict, and conflict_idx, and enter CAPTURE. start has priority; any in_valid sample in the same cycle is dropped.
- CAPTURE with in_valid and no start, for index i = in_vec:
  - seen[i]=0: set seen[i]=1, set minterms[i]=in_f, increment seen_cnt.
  - seen[i]=1 and in_f == minterms[i]: no change (duplicate).
  - seen[i]=1 and in_f != minterms[i]: conflict handling per Configuration.
- When a sample completes coverage (seen becomes all-ones), enter DONE on the same edge. match is loaded on that edge from the updated mask against exp_mask.
- in_valid is ignored in IDLE and DONE. All outputs hold in DONE until start or reset.
- seen_cnt saturates naturally at TT_W (N_IN+1 bits); it never wraps.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-capture) sets:
  - state = IDLE
  - busy = 0, done = 0, match = 0, conflict = 0
  - minterms = 0, seen = 0, seen_cnt = 0, conflict_idx = 0
- All outputs are registered. A sample accepted at edge k is reflected in minterms, seen, seen_cnt, and conflict after edge k.
- Throughput: one sample per cycle, with no backpressure.
- Completion latency: done and match are high after the edge that accepts the last new index. The minimum capture length is TT_W cycles after start.
- busy is high on the cycle after the start edge.

## Configuration
- TT_CONFLICT_EN defined:
  - A conflicting sample sets conflict=1 (sticky until start or reset).
  - conflict_idx latches only the first conflicting index.
  - minterms keeps the first-recorded value (first wins).
- TT_CONFLICT_EN undefined:
  - conflict and conflict_idx are tied to 0.
  - A conflicting sample overwrites minterms[i] with in_f (last wins).
  - seen_cnt is unchanged.

## Test plan
- Full sweep of f = ab | b~c, in_vec 0..15 one per cycle after start, exp_mask=16'hF030: done high after the 16th sample, minterms=16'hF030, seen_cnt=16, match=1, conflict=0.
- Same sweep with exp_mask=16'hF070: done=1, match=0.
- Reversed order 15..0 with duplicates of index 3 (f=0) inserted, exp_mask=16'hF030: seen_cnt increments only on new indices, done after the last new index, match=1.
- With TT_CONFLICT_EN, index 5 sent with f=1 then f=0, then a second conflict at index 9: conflict=1, conflict_idx=5, minterms[5]=1. Without the macro: conflict=0, minterms[5]=0.
- rst_n pulsed low mid-capture after 7 samples: all outputs return to reset values immediately. A following start plus a full sweep gives done=1, match=1.
- start together with in_valid (in_vec=4, f=1) while in DONE: sample dropped, seen=0, seen_cnt=0, busy=1, done=0 on the next cycle.
